// File: rtl/dual_edge_count_checker.sv
// Checks a dual-edge counter stream: pairs of {posedge, negedge} samples must
// advance by one per edge (mod 2^W); locks after LOCK_N good pairs and flags breaks.
module dual_edge_count_checker #(
  parameter int W      = 4,
  parameter int LOCK_N = 4,
  parameter int ERRW   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [W-1:0]      din,
  output logic              pair_valid,
  output logic [2*W-1:0]    pair_out,
  output logic              lock,
  output logic              err,
  output logic [ERRW-1:0]   err_count
);

  typedef enum logic [1:0] {IDLE, ACQ, LOCKED} state_t;

  state_t            state_q, state_d;
  logic [W-1:0]      rise_q, fall_q;
  logic              rvld_q, fvld_q;
  logic [W-1:0]      last_q, last_d;
  logic [3:0]        gcnt_q, gcnt_d;
  logic [2*W-1:0]    pair_q, pair_d;
  logic              pv_q, pv_d;
  logic              err_q, err_d;
  logic [ERRW-1:0]   ec_q, ec_d;

  logic [W-1:0]      last_inc, rise_inc;
  logic              pair_avail, good;

  // rvld/fvld track that both halves were captured after reset, so a
  // partial pair straddling reset release is never evaluated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      rvld_q <= 1'b0;
    end else begin
      rise_q <= din;
      rvld_q <= 1'b1;
    end
  end

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      fall_q <= '0;
      fvld_q <= 1'b0;
    end else begin
      fall_q <= din;
      fvld_q <= rvld_q;
    end
  end

  assign last_inc   = last_q + 1'b1;
  assign rise_inc   = rise_q + 1'b1;
  assign pair_avail = rvld_q & fvld_q;
  assign good       = (rise_q == last_inc) && (fall_q == rise_inc);

  always_comb begin
    state_d = state_q;
    gcnt_d  = gcnt_q;
    last_d  = last_q;
    pair_d  = pair_q;
    pv_d    = 1'b0;
    err_d   = 1'b0;
    ec_d    = ec_q;
    if (!en) begin
      state_d = IDLE;
    end else if (pair_avail) begin
      pv_d   = 1'b1;
      pair_d = {rise_q, fall_q};
      last_d = fall_q;
      case (state_q)
        IDLE: begin
          state_d = ACQ;
          gcnt_d  = '0;
        end
        ACQ: begin
          if (good) begin
            gcnt_d = gcnt_q + 4'd1;
            if (gcnt_q == 4'(LOCK_N - 1)) state_d = LOCKED;
          end else begin
            gcnt_d = '0;
          end
        end
        LOCKED: begin
          if (!good) begin
            err_d   = 1'b1;
            gcnt_d  = '0;
            state_d = ACQ;
            if (ec_q != '1) ec_d = ec_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gcnt_q  <= '0;
      last_q  <= '0;
      pair_q  <= '0;
      pv_q    <= 1'b0;
      err_q   <= 1'b0;
      ec_q    <= '0;
    end else begin
      state_q <= state_d;
      gcnt_q  <= gcnt_d;
      last_q  <= last_d;
      pair_q  <= pair_d;
      pv_q    <= pv_d;
      err_q   <= err_d;
      ec_q    <= ec_d;
    end
  end

  assign pair_valid = pv_q;
  assign pair_out   = pair_q;
  assign lock       = (state_q == LOCKED);
  assign err        = err_q;
  assign err_count  = ec_q;

endmodule

// File: tb/tb_dual_edge_count_checker.sv
// Scoreboard bench: each step pushes the hand-derived result of its pair,
// a negedge monitor pops and compares whenever pair_valid is seen.
module tb_dual_edge_count_checker;

  logic       clk, rst, en;
  logic [3:0] din;
  logic       pair_valid, lock, err;
  logic [7:0] pair_out;
  logic [1:0] err_count;

  dual_edge_count_checker #(.W(4), .LOCK_N(4), .ERRW(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .pair_valid (pair_valid),
    .pair_out   (pair_out),
    .lock       (lock),
    .err        (err),
    .err_count  (err_count)
  );

  typedef struct packed {
    logic [7:0] po;
    logic       lk;
    logic       er;
    logic [1:0] ec;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;
  int   err_pulses = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // din = a is captured at the posedge, b at the following negedge; e is
  // stable at the posedge that evaluates (a,b).
  task automatic step(input logic [3:0] a, input logic [3:0] b, input logic e,
                      input logic xlk, input logic xer, input logic [1:0] xec);
    exp_t x;
    @(negedge clk); #1 din = a;
    @(posedge clk); #1 din = b; en = e;
    if (e) begin
      x.po = {a, b};
      x.lk = xlk;
      x.er = xer;
      x.ec = xec;
      q.push_back(x);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (!rst) begin
      if (pair_valid) begin
        if (err) err_pulses++;
        if (q.size() == 0) begin
          chk("unexpected_pair_valid", {31'd0, pair_valid}, 32'd0);
        end else begin
          x = q.pop_front();
          chk("pair_out", {24'd0, pair_out}, {24'd0, x.po});
          chk("lock", {31'd0, lock}, {31'd0, x.lk});
          chk("err", {31'd0, err}, {31'd0, x.er});
          chk("err_count", {30'd0, err_count}, {30'd0, x.ec});
        end
      end else if (err) begin
        chk("err_without_pair", {31'd0, err}, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_zero(input string tag);
    chk({tag, "_pair_valid"}, {31'd0, pair_valid}, 32'd0);
    chk({tag, "_pair_out"}, {24'd0, pair_out}, 32'd0);
    chk({tag, "_lock"}, {31'd0, lock}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_err_count"}, {30'd0, err_count}, 32'd0);
  endtask

  initial begin
    logic [3:0] v;
    int         p0;
    logic [1:0] ec;
    rst = 1'b1; en = 1'b0; din = 4'd0;
    #12 chk_zero("reset");
    #10 rst = 1'b0;

    // S1: stream 1,2,3,... ; lock on the 5th pair (9,A)
    v = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step(v, v + 4'd1, 1'b1, (i == 4), 1'b0, 2'd0);
      v = v + 4'd2;
    end

    // S2: wrap F->0 while locked
    step(4'hB, 4'hC, 1'b1, 1'b1, 1'b0, 2'd0);
    step(4'hD, 4'hE, 1'b1, 1'b1, 1'b0, 2'd0);
    step(4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd0);
    step(4'h1, 4'h2, 1'b1, 1'b1, 1'b0, 2'd0);

    // S3: corrupted fall sample, then the counter continues 7,8,...
    step(4'h3, 4'h4, 1'b1, 1'b1, 1'b0, 2'd0);
    step(4'h5, 4'h7, 1'b1, 1'b0, 1'b1, 2'd1);
    step(4'h7, 4'h8, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'h9, 4'hA, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'hB, 4'hC, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'hD, 4'hE, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1);

    // S6: en low for 3 cycles while locked
    step(4'h1, 4'h2, 1'b0, 1'b0, 1'b0, 2'd1);
    step(4'h3, 4'h4, 1'b0, 1'b0, 1'b0, 2'd1);
    step(4'h5, 4'h6, 1'b0, 1'b0, 1'b0, 2'd1);
    chk("disabled_lock", {31'd0, lock}, 32'd0);
    chk("disabled_err_count", {30'd0, err_count}, 32'd1);
    step(4'h7, 4'h8, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'h9, 4'hA, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'hB, 4'hC, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'hD, 4'hE, 1'b1, 1'b0, 1'b0, 2'd1);
    step(4'hF, 4'h0, 1'b1, 1'b1, 1'b0, 2'd1);

    // S5: async reset between edges while locked
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1; en = 1'b0;
    #1 chk_zero("midrst");
    #20 rst = 1'b0;
    v = 4'd1;
    for (int i = 0; i < 5; i++) begin
      step(v, v + 4'd1, 1'b1, (i == 4), 1'b0, 2'd0);
      v = v + 4'd2;
    end

    // S4: five locked errors, counter saturates at 3
    p0 = err_pulses;
    ec = 2'd0;
    for (int e = 0; e < 5; e++) begin
      if (ec != 2'd3) ec = ec + 2'd1;
      step(v, v + 4'd2, 1'b1, 1'b0, 1'b1, ec);
      v = v + 4'd3;
      for (int j = 0; j < 4; j++) begin
        step(v, v + 4'd1, 1'b1, (j == 3), 1'b0, ec);
        v = v + 4'd2;
      end
    end

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("err_pulses", err_pulses - p0, 32'd5);
    chk("queue_drained", q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
